// File: rtl/demux_32_bit_stream_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer: default word width,
// select encodings and output count.
package demux_32_bit_stream_pkg;
  localparam int   WIDTH_DEF = 32;
  localparam int   NUM_OUTS  = 2;
  localparam logic SEL_OUT_0 = 1'b0;
  localparam logic SEL_OUT_1 = 1'b1;
endpackage

// File: rtl/demux_out_fifo.sv
// Per-output FIFO: storage, wrap-around pointers and occupancy level.
// Push and pop are qualified internally so overflow/underflow cannot occur.
module demux_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LVLW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [LVLW-1:0]  level
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0]             level_q, level_d;
  logic [WIDTH-1:0]            last_q, last_d;
  logic                        do_push, do_pop;

  assign full  = (level_q == LVLW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  // Once drained, keep presenting the word that was last at the head.
  assign head  = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    if (do_push && !do_pop)      level_d = level_q + LVLW'(1);
    else if (!do_push && do_pop) level_d = level_q - LVLW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end
endmodule

// File: rtl/demux_32_bit_stream.sv
// Registered 1-to-2 demultiplexer: steers each accepted input word into one of
// two independent output FIFOs chosen by select.
module demux_32_bit_stream
  import demux_32_bit_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter int LVLW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             select,
  output logic             out_0_valid,
  input  logic             out_0_ready,
  output logic [WIDTH-1:0] out_0_data,
  output logic             out_1_valid,
  input  logic             out_1_ready,
  output logic [WIDTH-1:0] out_1_data,
  output logic [LVLW-1:0]  level_0,
  output logic [LVLW-1:0]  level_1
);
  logic [NUM_OUTS-1:0]             sel_dec, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NUM_OUTS-1:0][WIDTH-1:0]  fifo_head;
  logic [NUM_OUTS-1:0][LVLW-1:0]   fifo_level;

  // Readiness only looks at the selected FIFO's full flag, never at consumer ready.
  assign in_ready   = (select == SEL_OUT_1) ? ~fifo_full[1] : ~fifo_full[0];
  assign sel_dec    = {select == SEL_OUT_1, select == SEL_OUT_0};
  assign fifo_push  = {NUM_OUTS{in_valid & in_ready}} & sel_dec;
  assign fifo_pop   = {out_1_ready, out_0_ready};

  for (genvar gi = 0; gi < NUM_OUTS; gi++) begin : g_fifo
    demux_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVLW(LVLW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[gi]),
      .din   (in_data),
      .pop   (fifo_pop[gi]),
      .full  (fifo_full[gi]),
      .empty (fifo_empty[gi]),
      .head  (fifo_head[gi]),
      .level (fifo_level[gi])
    );
  end

  assign out_0_valid = ~fifo_empty[0];
  assign out_1_valid = ~fifo_empty[1];
  assign out_0_data  = fifo_head[0];
  assign out_1_data  = fifo_head[1];
  assign level_0     = fifo_level[0];
  assign level_1     = fifo_level[1];
endmodule
